// File: rtl/jtag_tap_multi_dr.sv
// IEEE 1149.1 TAP with instruction register, shared DR shift path and N_CHAN user DR channels.
// Optional IDCODE register enabled by defining JTAG_IDCODE_EN.
module jtag_tap_multi_dr #(
  parameter int                  IR_WIDTH   = 6,
  parameter int                  DR_WIDTH   = 32,
  parameter int                  N_CHAN     = 4,
  parameter logic [IR_WIDTH-1:0] USER_OP0   = 6'h02,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 6'h09,
  parameter logic [DR_WIDTH-1:0] IDCODE_VAL = 32'h0
) (
  input  logic                       TCK,
  input  logic                       TRST,
  input  logic                       TMS,
  input  logic                       TDI,
  output logic                       TDO,
  output logic                       TDO_EN,
  output logic [IR_WIDTH-1:0]        IR,
  output logic [N_CHAN-1:0]          SEL,
  input  logic [N_CHAN*DR_WIDTH-1:0] USR_DIN,
  output logic [DR_WIDTH-1:0]        USR_DOUT,
  output logic [N_CHAN-1:0]          CAP,
  output logic [N_CHAN-1:0]          UPDT,
  output logic                       TLRESET,
  output logic                       RTIDLE
);

  localparam logic [3:0] TLR      = 4'hF;
  localparam logic [3:0] RTI      = 4'hC;
  localparam logic [3:0] SEL_DR   = 4'h7;
  localparam logic [3:0] CAP_DR   = 4'h6;
  localparam logic [3:0] SHIFT_DR = 4'h2;
  localparam logic [3:0] EXIT1_DR = 4'h1;
  localparam logic [3:0] PAUSE_DR = 4'h3;
  localparam logic [3:0] EXIT2_DR = 4'h0;
  localparam logic [3:0] UPD_DR   = 4'h5;
  localparam logic [3:0] SEL_IR   = 4'h4;
  localparam logic [3:0] CAP_IR   = 4'hE;
  localparam logic [3:0] SHIFT_IR = 4'hA;
  localparam logic [3:0] EXIT1_IR = 4'h9;
  localparam logic [3:0] PAUSE_IR = 4'hB;
  localparam logic [3:0] EXIT2_IR = 4'h8;
  localparam logic [3:0] UPD_IR   = 4'hD;

`ifdef JTAG_IDCODE_EN
  localparam logic IDCODE_EN_C = 1'b1;
`else
  localparam logic IDCODE_EN_C = 1'b0;
`endif

  localparam logic [IR_WIDTH-1:0] RESET_OP   = IDCODE_EN_C ? IDCODE_OP : {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  logic [3:0]          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q, ir_diff_s;
  logic [DR_WIDTH-1:0] dr_sr_q, dout_q, cap_data_s;
  logic                byp_q, tdo_q, tdo_en_q, tlr_q, rti_q;
  logic [N_CHAN-1:0]   sel_s, cap_q, updt_q;
  logic                user_hit_s, idcode_hit_s, long_dr_s;

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:      state_d = TMS ? TLR      : RTI;
      RTI:      state_d = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = TMS ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_d = TMS ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_d = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_d = TMS ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = TMS ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_d = TMS ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_d = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_d = TMS ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Channel k is selected when IR - USER_OP0 == k; user opcodes win over IDCODE_OP.
  assign ir_diff_s    = ir_q - USER_OP0;
  assign user_hit_s   = (int'(ir_diff_s) < N_CHAN);
  assign idcode_hit_s = IDCODE_EN_C && !user_hit_s && (ir_q == IDCODE_OP);
  assign long_dr_s    = user_hit_s || idcode_hit_s;

  always_comb begin
    sel_s = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      sel_s[k] = user_hit_s && (ir_diff_s == IR_WIDTH'(k));
    end
  end

  always_comb begin
    cap_data_s = IDCODE_VAL;
    for (int k = 0; k < N_CHAN; k++) begin
      if (sel_s[k]) begin
        cap_data_s = USR_DIN[k*DR_WIDTH +: DR_WIDTH];
      end else begin
        cap_data_s = cap_data_s;
      end
    end
  end

  // Strobes are registered from the next state so they align with the state they flag.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= TLR;
      tlr_q   <= 1'b1;
      rti_q   <= 1'b0;
      cap_q   <= '0;
      updt_q  <= '0;
    end else begin
      state_q <= state_d;
      tlr_q   <= (state_d == TLR);
      rti_q   <= (state_d == RTI);
      cap_q   <= (state_d == CAP_DR) ? sel_s : '0;
      updt_q  <= (state_d == UPD_DR) ? sel_s : '0;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_q    <= RESET_OP;
      ir_sr_q <= '0;
    end else begin
      if (state_q == CAP_IR) begin
        ir_sr_q <= IR_CAPTURE;
      end else if (state_q == SHIFT_IR) begin
        ir_sr_q <= {TDI, ir_sr_q[IR_WIDTH-1:1]};
      end
      if (state_d == UPD_IR) begin
        ir_q <= ir_sr_q;
      end else if (state_d == TLR) begin
        ir_q <= RESET_OP;
      end
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      dr_sr_q <= '0;
      byp_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      if (state_q == CAP_DR) begin
        if (long_dr_s) begin
          dr_sr_q <= cap_data_s;
        end else begin
          byp_q <= 1'b0;
        end
      end else if (state_q == SHIFT_DR) begin
        if (long_dr_s) begin
          dr_sr_q <= {TDI, dr_sr_q[DR_WIDTH-1:1]};
        end else begin
          byp_q <= TDI;
        end
      end
      if ((state_d == UPD_DR) && user_hit_s) begin
        dout_q <= dr_sr_q;
      end
    end
  end

  // TDO launches on the falling edge so the capturing device sees a stable bit at posedge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
      if (state_q == SHIFT_IR) begin
        tdo_q <= ir_sr_q[0];
      end else if (state_q == SHIFT_DR) begin
        tdo_q <= long_dr_s ? dr_sr_q[0] : byp_q;
      end else begin
        tdo_q <= 1'b0;
      end
    end
  end

  assign TDO      = tdo_q;
  assign TDO_EN   = tdo_en_q;
  assign IR       = ir_q;
  assign SEL      = sel_s;
  assign USR_DOUT = dout_q;
  assign CAP      = cap_q;
  assign UPDT     = updt_q;
  assign TLRESET  = tlr_q;
  assign RTIDLE   = rti_q;

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Bench for jtag_tap_multi_dr: vector table, directed scans and random scans checked
// against a state-name-level TAP reference model. Honours JTAG_IDCODE_EN.
module tb_jtag_tap_multi_dr;

  logic         TCK = 1'b0;
  logic         TRST, TMS, TDI;
  logic         TDO, TDO_EN, TLRESET, RTIDLE;
  logic [5:0]   IR;
  logic [3:0]   SEL, CAP, UPDT;
  logic [127:0] USR_DIN;
  logic [31:0]  USR_DOUT;

  localparam logic [31:0] IDV = 32'h1234_5093;
`ifdef JTAG_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [5:0] RST_OP = ID_EN ? 6'h09 : 6'h3F;

  jtag_tap_multi_dr #(.IDCODE_VAL(IDV)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .IR(IR), .SEL(SEL), .USR_DIN(USR_DIN), .USR_DOUT(USR_DOUT), .CAP(CAP),
    .UPDT(UPDT), .TLRESET(TLRESET), .RTIDLE(RTIDLE)
  );

  always #10 TCK = ~TCK;

  int n_chk = 0;
  int n_pass = 0;
  int cap1_cnt, updt1_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef enum int {S_TLR, S_RTI, S_SELDR, S_CAPDR, S_SHDR, S_EX1DR, S_PDR, S_EX2DR, S_UPDR,
                    S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PIR, S_EX2IR, S_UPIR} tap_e;

  tap_e        m_st;
  logic [5:0]  m_ir, m_irs;
  logic [31:0] m_drs, m_dout;
  logic        m_byp;
  logic [3:0]  m_cap, m_updt;

  function automatic tap_e tap_next(tap_e s, logic tms);
    case (s)
      S_TLR:   return tms ? S_TLR   : S_RTI;
      S_RTI:   return tms ? S_SELDR : S_RTI;
      S_SELDR: return tms ? S_SELIR : S_CAPDR;
      S_CAPDR, S_SHDR: return tms ? S_EX1DR : S_SHDR;
      S_EX1DR: return tms ? S_UPDR  : S_PDR;
      S_PDR:   return tms ? S_EX2DR : S_PDR;
      S_EX2DR: return tms ? S_UPDR  : S_SHDR;
      S_SELIR: return tms ? S_TLR   : S_CAPIR;
      S_CAPIR, S_SHIR: return tms ? S_EX1IR : S_SHIR;
      S_EX1IR: return tms ? S_UPIR  : S_PIR;
      S_PIR:   return tms ? S_EX2IR : S_PIR;
      S_EX2IR: return tms ? S_UPIR  : S_SHIR;
      default: return tms ? S_SELDR : S_RTI;  // both Update states
    endcase
  endfunction

  function automatic int chan_of(logic [5:0] ir);
    int d;
    d = (int'(ir) - 2 + 64) % 64;
    return (d < 4) ? d : -1;
  endfunction

  function automatic logic [3:0] sel_of(logic [5:0] ir);
    int c;
    c = chan_of(ir);
    return (c < 0) ? 4'b0000 : 4'(1 << c);
  endfunction

  function automatic bit long_of(logic [5:0] ir);
    return (chan_of(ir) >= 0) || (ID_EN && ir == 6'h09);
  endfunction

  task automatic model_reset();
    m_st = S_TLR; m_ir = RST_OP; m_irs = 6'h00; m_drs = 32'h0; m_byp = 1'b0;
    m_dout = 32'h0; m_cap = 4'h0; m_updt = 4'h0;
  endtask

  task automatic model_pos(input logic tms, input logic tdi);
    tap_e ns;
    int   c;
    ns = tap_next(m_st, tms);
    c  = chan_of(m_ir);
    if (m_st == S_CAPIR) m_irs = 6'h01;
    else if (m_st == S_SHIR) m_irs = (m_irs >> 1) | (6'(tdi) << 5);
    else if (m_st == S_CAPDR) begin
      if (c >= 0) m_drs = USR_DIN[c*32 +: 32];
      else if (long_of(m_ir)) m_drs = IDV;
      else m_byp = 1'b0;
    end else if (m_st == S_SHDR) begin
      if (long_of(m_ir)) m_drs = (m_drs >> 1) | (32'(tdi) << 31);
      else m_byp = tdi;
    end
    m_cap  = (ns == S_CAPDR) ? sel_of(m_ir) : 4'h0;
    m_updt = (ns == S_UPDR)  ? sel_of(m_ir) : 4'h0;
    if (ns == S_UPDR && c >= 0) m_dout = m_drs;
    if (ns == S_UPIR) m_ir = m_irs;
    else if (ns == S_TLR) m_ir = RST_OP;
    m_st = ns;
  endtask

  function automatic logic exp_tdo();
    if (m_st == S_SHIR) return m_irs[0];
    if (m_st == S_SHDR) return long_of(m_ir) ? m_drs[0] : m_byp;
    return 1'b0;
  endfunction

  task automatic check_pos();
    chk("TLRESET", 32'(TLRESET), 32'(m_st == S_TLR));
    chk("RTIDLE", 32'(RTIDLE), 32'(m_st == S_RTI));
    chk("IR", 32'(IR), 32'(m_ir));
    chk("SEL", 32'(SEL), 32'(sel_of(m_ir)));
    chk("CAP", 32'(CAP), 32'(m_cap));
    chk("UPDT", 32'(UPDT), 32'(m_updt));
    chk("USR_DOUT", USR_DOUT, m_dout);
  endtask

  task automatic check_neg();
    chk("TDO", 32'(TDO), 32'(exp_tdo()));
    chk("TDO_EN", 32'(TDO_EN), 32'(m_st == S_SHIR || m_st == S_SHDR));
  endtask

  // One TCK: drive, posedge, check strobes, negedge, check TDO. Returns just after negedge.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge TCK);
    model_pos(tms, tdi);
    #1;
    check_pos();
    if (CAP[1]) cap1_cnt++;
    if (UPDT[1]) updt1_cnt++;
    @(negedge TCK);
    #1;
    check_neg();
  endtask

  task automatic do_trst();
    TRST = 1'b1;
    #2;
    model_reset();
    check_pos();
    check_neg();
    TRST = 1'b0;
    #1;
  endtask

  task automatic ir_scan(input logic [5:0] op, output logic [5:0] cap_out);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cap_out[i] = TDO;
      step(i == 5, op[i]);
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = 32'h0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic go_rti();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  typedef struct {
    logic       tms, tdi;
    logic       e_tlr, e_rti, e_en, e_tdo;
    logic [5:0] e_ir;
  } vec_t;

  vec_t        tbl[13];
  logic [5:0]  irc;
  logic [31:0] word;
  logic [5:0]  ops[7];

  initial begin
    // tms tdi | tlr rti tdo_en tdo ir  -- IR scan of 6'h03 from Test_Logic_Reset
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, RST_OP};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST_OP};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST_OP};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST_OP};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RST_OP};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RST_OP};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RST_OP};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST_OP};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST_OP};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, RST_OP};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RST_OP};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h03};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h03};
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h3F, 6'h00};

    TMS = 1'b1; TDI = 1'b0; USR_DIN = 128'h0; TRST = 1'b1;
    #5;
    model_reset();
    check_pos();
    check_neg();
    TRST = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].tms, tbl[i].tdi);
      chk("vec_tlr", 32'(TLRESET), 32'(tbl[i].e_tlr));
      chk("vec_rti", 32'(RTIDLE), 32'(tbl[i].e_rti));
      chk("vec_tdo_en", 32'(TDO_EN), 32'(tbl[i].e_en));
      chk("vec_tdo", 32'(TDO), 32'(tbl[i].e_tdo));
      chk("vec_ir", 32'(IR), 32'(tbl[i].e_ir));
    end
    chk("vec_sel", 32'(SEL), 32'h2);

    // user channel 1 DR scan
    USR_DIN = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
    ir_scan(6'h03, irc);
    chk("ch1_sel", 32'(SEL), 32'h2);
    cap1_cnt = 0; updt1_cnt = 0;
    dr_scan(32'hA5A5_0F0F, 32, word);
    chk("ch1_tdo_word", word, 32'h1234_5678);
    chk("ch1_cap_pulses", 32'(cap1_cnt), 32'd1);
    chk("ch1_updt_pulses", 32'(updt1_cnt), 32'd1);
    chk("ch1_usr_dout", USR_DOUT, 32'hA5A5_0F0F);

    // bypass: first bit 0 then TDI delayed by one TCK
    ir_scan(6'h3F, irc);
    chk("byp_sel", 32'(SEL), 32'h0);
    dr_scan(32'h0000_00C3, 8, word);
    chk("byp_tdo", 32'(word[7:0]), 32'h86);
    chk("byp_dout_held", USR_DOUT, 32'hA5A5_0F0F);

    // IR capture pattern and non-user opcode
    ir_scan(6'h2A, irc);
    chk("ir_capture", 32'(irc), 32'h01);
    chk("ir_2a", 32'(IR), 32'h2A);
    chk("ir_2a_sel", 32'(SEL), 32'h0);

    // DR scan after TLR: IDCODE or one bypass bit
    go_rti();
    dr_scan(32'h0, 32, word);
    chk("post_tlr_dr", word, ID_EN ? IDV : 32'h0);

    // five TMS=1 from Shift_IR
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1);
      chk("tms5_tlr", 32'(TLRESET), 32'(i == 4));
    end
    chk("tms5_ir", 32'(IR), 32'(RST_OP));
    step(1'b0, 1'b0);

    // TRST in the middle of a channel-2 Shift_DR
    USR_DIN[95:64] = 32'hDEAD_BEEF;
    ir_scan(6'h04, irc);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    do_trst();
    chk("trst_tlr", 32'(TLRESET), 32'h1);
    chk("trst_sel", 32'(SEL), 32'h0);
    chk("trst_updt", 32'(UPDT), 32'h0);
    chk("trst_ir", 32'(IR), 32'(RST_OP));
    chk("trst_dout", USR_DOUT, 32'h0);
    step(1'b0, 1'b0);

    // random scans, stray TMS activity and occasional TRST against the model
    for (int it = 0; it < 40; it++) begin
      ops[6] = 6'($urandom_range(0, 63));
      USR_DIN = {$urandom, $urandom, $urandom, $urandom};
      ir_scan(ops[$urandom_range(0, 6)], irc);
      dr_scan($urandom, $urandom_range(1, 32), word);
      for (int j = 0; j < int'($urandom_range(0, 12)); j++) step(1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) do_trst();
      go_rti();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
